pipeline_hazard_ctrl: RTL and testbench

Hazard and forwarding controller for the five-stage MIPS pipeline. It watches register fields and control bits in the D, E, M and W stages, and drives three things: the stall enables for the F/D pipeline registers, the `clear` input of the D/E pipeline register, and the forwarding multiplexer selects. It also owns a cycle counter that tracks the multi-cycle multiply/divide unit, so that HI/LO consumers are held until the result is valid.

---
 rtl/pipeline_hazard_ctrl.sv | 114 +++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard detection and forwarding control for a five-stage MIPS pipeline,
// including the busy counter that tracks the multi-cycle mult/div unit.
module pipeline_hazard_ctrl #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10,
  parameter int unsigned CW      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    rs_D,
  input  logic [4:0]    rt_D,
  input  logic          branch_D,
  input  logic          jr_D,
  input  logic          md_D,
  input  logic [4:0]    rs_E,
  input  logic [4:0]    rt_E,
  input  logic [4:0]    wa_E,
  input  logic [4:0]    wa_M,
  input  logic [4:0]    wa_W,
  input  logic          we_E,
  input  logic          we_M,
  input  logic          we_W,
  input  logic          memread_E,
  input  logic          memread_M,
  input  logic          md_start_E,
  input  logic          md_is_div_E,
  output logic          stall_F,
  output logic          stall_D,
  output logic          clear_E,
  output logic          fwd_rs_D,
  output logic          fwd_rt_D,
  output logic [1:0]    fwd_a_E,
  output logic [1:0]    fwd_b_E,
  output logic          md_busy,
  output logic [CW-1:0] md_left
);

  localparam logic [CW-1:0] MulLat = CW'(MUL_LAT);
  localparam logic [CW-1:0] DivLat = CW'(DIV_LAT);

  logic [CW-1:0] md_left_q, md_left_d;
  logic          w_e, w_m, w_w;
  logic          load_use, branch_haz, jr_haz, md_haz, stall;
  logic          fwd_rs_d_raw, fwd_rt_d_raw;
  logic [1:0]    fwd_a_raw, fwd_b_raw;

  always_comb begin
    md_left_d = md_left_q;
    if (md_start_E) begin
      md_left_d = md_is_div_E ? DivLat : MulLat;
    end else if (md_left_q != '0) begin
      md_left_d = md_left_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_left_q <= '0;
    end else begin
      md_left_q <= md_left_d;
    end
  end

  always_comb begin
    w_e = we_E && (wa_E != 5'd0);
    w_m = we_M && (wa_M != 5'd0);
    w_w = we_W && (wa_W != 5'd0);

    load_use   = memread_E && w_e && ((wa_E == rs_D) || (wa_E == rt_D));
    branch_haz = branch_D &&
                 ((w_e && ((wa_E == rs_D) || (wa_E == rt_D))) ||
                  (memread_M && w_m && ((wa_M == rs_D) || (wa_M == rt_D))));
    jr_haz     = jr_D && ((w_e && (wa_E == rs_D)) ||
                          (memread_M && w_m && (wa_M == rs_D)));
    md_haz     = md_D && ((md_left_q != '0) || md_start_E);
    stall      = load_use || branch_haz || jr_haz || md_haz;

    // A load in M has no ALU result to offer; D waits on the stall instead.
    fwd_rs_d_raw = w_m && !memread_M && (wa_M == rs_D);
    fwd_rt_d_raw = w_m && !memread_M && (wa_M == rt_D);

    fwd_a_raw = 2'b00;
    if (w_m && (wa_M == rs_E))      fwd_a_raw = 2'b10;
    else if (w_w && (wa_W == rs_E)) fwd_a_raw = 2'b01;

    fwd_b_raw = 2'b00;
    if (w_m && (wa_M == rt_E))      fwd_b_raw = 2'b10;
    else if (w_w && (wa_W == rt_E)) fwd_b_raw = 2'b01;
  end

  // Outputs are forced low for the whole reset window, not just the registers.
  always_comb begin
    stall_F  = 1'b0;
    stall_D  = 1'b0;
    clear_E  = 1'b0;
    fwd_rs_D = 1'b0;
    fwd_rt_D = 1'b0;
    fwd_a_E  = 2'b00;
    fwd_b_E  = 2'b00;
    md_busy  = 1'b0;
    md_left  = md_left_q;
    if (reset) begin
      stall_F  = stall;
      stall_D  = stall;
      clear_E  = stall;
      fwd_rs_D = fwd_rs_d_raw;
      fwd_rt_D = fwd_rt_d_raw;
      fwd_a_E  = fwd_a_raw;
      fwd_b_E  = fwd_b_raw;
      md_busy  = (md_left_q != '0);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios plus random stimulus,
// all checked against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_D, rt_D, rs_E, rt_E, wa_E, wa_M, wa_W;
  logic       branch_D, jr_D, md_D, we_E, we_M, we_W;
  logic       memread_E, memread_M, md_start_E, md_is_div_E;
  logic       stall_F, stall_D, clear_E, fwd_rs_D, fwd_rt_D, md_busy;
  logic [1:0] fwd_a_E, fwd_b_E;
  logic [3:0] md_left;

  int total = 0;
  int bad   = 0;
  int m_left = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_LAT(5), .DIV_LAT(10), .CW(4)) dut (
    .clk(clk), .reset(reset),
    .rs_D(rs_D), .rt_D(rt_D), .branch_D(branch_D), .jr_D(jr_D), .md_D(md_D),
    .rs_E(rs_E), .rt_E(rt_E), .wa_E(wa_E), .wa_M(wa_M), .wa_W(wa_W),
    .we_E(we_E), .we_M(we_M), .we_W(we_W),
    .memread_E(memread_E), .memread_M(memread_M),
    .md_start_E(md_start_E), .md_is_div_E(md_is_div_E),
    .stall_F(stall_F), .stall_D(stall_D), .clear_E(clear_E),
    .fwd_rs_D(fwd_rs_D), .fwd_rt_D(fwd_rt_D),
    .fwd_a_E(fwd_a_E), .fwd_b_E(fwd_b_E),
    .md_busy(md_busy), .md_left(md_left)
  );

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    {rs_D, rt_D, rs_E, rt_E, wa_E, wa_M, wa_W} = '0;
    {branch_D, jr_D, md_D, we_E, we_M, we_W} = '0;
    {memread_E, memread_M, md_start_E, md_is_div_E} = '0;
  endtask

  // Advance one clock and update the model counter from the pre-edge inputs.
  task automatic tick();
    bit st, dv;
    st = md_start_E;
    dv = md_is_div_E;
    @(posedge clk);
    #1;
    if (!reset)      m_left = 0;
    else if (st)     m_left = dv ? 10 : 5;
    else if (m_left > 0) m_left = m_left - 1;
  endtask

  function automatic logic [1:0] fsel(input logic [4:0] src, input bit wm, input bit ww);
    if (wm && wa_M == src) return 2'b10;
    if (ww && wa_W == src) return 2'b01;
    return 2'b00;
  endfunction

  task automatic check_all(input string tag);
    bit wE, wM, wW, st, on;
    logic [1:0] ea, eb;
    wE = we_E && wa_E != 0;
    wM = we_M && wa_M != 0;
    wW = we_W && wa_W != 0;
    on = reset;
    st = (memread_E && wE && (wa_E == rs_D || wa_E == rt_D))
      || (branch_D && ((wE && (wa_E == rs_D || wa_E == rt_D))
                    || (memread_M && wM && (wa_M == rs_D || wa_M == rt_D))))
      || (jr_D && ((wE && wa_E == rs_D) || (memread_M && wM && wa_M == rs_D)))
      || (md_D && (m_left != 0 || md_start_E));
    ea = on ? fsel(rs_E, wM, wW) : 2'b00;
    eb = on ? fsel(rt_E, wM, wW) : 2'b00;
    chk({tag, ".stall_F"}, 8'(stall_F), 8'(on && st));
    chk({tag, ".stall_D"}, 8'(stall_D), 8'(on && st));
    chk({tag, ".clear_E"}, 8'(clear_E), 8'(on && st));
    chk({tag, ".fwd_rs_D"}, 8'(fwd_rs_D), 8'(on && wM && !memread_M && wa_M == rs_D));
    chk({tag, ".fwd_rt_D"}, 8'(fwd_rt_D), 8'(on && wM && !memread_M && wa_M == rt_D));
    chk({tag, ".fwd_a_E"}, 8'(fwd_a_E), 8'(ea));
    chk({tag, ".fwd_b_E"}, 8'(fwd_b_E), 8'(eb));
    chk({tag, ".md_left"}, 8'(md_left), 8'(m_left));
    chk({tag, ".md_busy"}, 8'(md_busy), 8'(on && m_left != 0));
  endtask

  task automatic rand_inputs();
    rs_D = 5'($urandom_range(0, 3)); rt_D = 5'($urandom_range(0, 3));
    rs_E = 5'($urandom_range(0, 3)); rt_E = 5'($urandom_range(0, 3));
    wa_E = 5'($urandom_range(0, 3)); wa_M = 5'($urandom_range(0, 3));
    wa_W = 5'($urandom_range(0, 3));
    {branch_D, jr_D, md_D} = 3'($urandom);
    {we_E, we_M, we_W, memread_E, memread_M} = 5'($urandom);
    md_start_E  = ($urandom_range(0, 7) == 0);
    md_is_div_E = 1'($urandom);
  endtask

  initial begin
    // Reset state with busy-looking inputs
    reset = 1'b0;
    clear_inputs();
    rs_E = 5'd5; wa_M = 5'd5; we_M = 1'b1; memread_E = 1'b1; we_E = 1'b1;
    wa_E = 5'd5; rs_D = 5'd5; md_D = 1'b1; md_start_E = 1'b1;
    #12;
    check_all("reset");
    chk("reset.fwd_a_E_lit", 8'(fwd_a_E), 8'd0);
    #3 reset = 1'b1;
    clear_inputs();
    tick();

    // Load-use: one cycle, then the load moves to M
    memread_E = 1'b1; we_E = 1'b1; wa_E = 5'd8; rs_D = 5'd8;
    #1 check_all("lu0");
    chk("lu0.stall_lit", 8'(stall_F), 8'd1);
    tick();
    memread_E = 1'b0; we_E = 1'b0; wa_E = 5'd0;
    memread_M = 1'b1; we_M = 1'b1; wa_M = 5'd8;
    #1 check_all("lu1");
    chk("lu1.stall_lit", 8'(stall_D), 8'd0);
    clear_inputs();
    memread_E = 1'b1; we_E = 1'b1; wa_E = 5'd0; rs_D = 5'd0;
    #1 check_all("lu_r0");
    chk("lu_r0.stall_lit", 8'(clear_E), 8'd0);

    // Forward priority
    clear_inputs();
    wa_M = 5'd5; wa_W = 5'd5; we_M = 1'b1; we_W = 1'b1; rs_E = 5'd5;
    #1 check_all("fwdMW");
    chk("fwdMW.lit", 8'(fwd_a_E), 8'd2);
    we_M = 1'b0;
    #1 check_all("fwdW");
    chk("fwdW.lit", 8'(fwd_a_E), 8'd1);
    tick();

    // Branch after load: two stall cycles, no D forwarding
    clear_inputs();
    branch_D = 1'b1; rt_D = 5'd9;
    memread_E = 1'b1; we_E = 1'b1; wa_E = 5'd9;
    #1 check_all("br0");
    chk("br0.stall_lit", 8'(stall_F), 8'd1);
    chk("br0.fwd_rt_lit", 8'(fwd_rt_D), 8'd0);
    tick();
    {memread_E, we_E, wa_E} = '0;
    memread_M = 1'b1; we_M = 1'b1; wa_M = 5'd9;
    #1 check_all("br1");
    chk("br1.stall_lit", 8'(stall_F), 8'd1);
    chk("br1.fwd_rt_lit", 8'(fwd_rt_D), 8'd0);
    tick();
    {memread_M, we_M, wa_M} = '0;
    #1 check_all("br2");
    chk("br2.stall_lit", 8'(stall_F), 8'd0);

    // Divide busy window
    clear_inputs();
    md_D = 1'b1; md_start_E = 1'b1; md_is_div_E = 1'b1;
    #1 check_all("div_start");
    chk("div_start.stall_lit", 8'(stall_F), 8'd1);
    tick();
    md_start_E = 1'b0;
    for (int i = 10; i >= 1; i--) begin
      #1 check_all("div_busy");
      chk("div_busy.left_lit", 8'(md_left), 8'(i));
      chk("div_busy.stall_lit", 8'(stall_D), 8'd1);
      tick();
    end
    #1 check_all("div_done");
    chk("div_done.left_lit", 8'(md_left), 8'd0);
    chk("div_done.stall_lit", 8'(stall_D), 8'd0);

    // Restart: mult then div two cycles later
    clear_inputs();
    md_start_E = 1'b1;
    tick();
    md_start_E = 1'b0;
    tick();
    #1 check_all("rs_mul");
    md_start_E = 1'b1; md_is_div_E = 1'b1;
    tick();
    md_start_E = 1'b0;
    #1 check_all("rs_div");
    chk("rs_div.left_lit", 8'(md_left), 8'd10);

    // Async reset while md_left = 6, between edges
    for (int i = 0; i < 4; i++) tick();
    chk("ar_pre.left_lit", 8'(md_left), 8'd6);
    md_D = 1'b1; rs_E = 5'd3; wa_W = 5'd3; we_W = 1'b1;
    #2 reset = 1'b0;
    m_left = 0;
    #1 check_all("ar_in");
    chk("ar_in.left_lit", 8'(md_left), 8'd0);
    chk("ar_in.busy_lit", 8'(md_busy), 8'd0);
    #1 reset = 1'b1;
    tick();
    #1 check_all("ar_post0");
    tick();
    #1 check_all("ar_post1");
    chk("ar_post1.left_lit", 8'(md_left), 8'd0);

    // Random stimulus against the model
    for (int n = 0; n < 400; n++) begin
      rand_inputs();
      #1 check_all("rand");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
